// File: rtl/rand_pkg.sv
// Shared types, constants and the generator step function for rand_server.
package rand_pkg;

  localparam int unsigned GenW = 6;
  localparam logic [GenW-1:0] SeedDefault = 6'h09;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StAdvance
  } state_e;

  // One step of the 6-bit generator; all-zero maps to itself.
  function automatic logic [GenW-1:0] prng_step(input logic [GenW-1:0] s);
    return {s[5] ^ s[4],
            s[4] ^ s[3],
            s[4],
            s[2] ^ s[1],
            s[1] ^ s[0],
            s[0] ^ s[3] ^ s[2]};
  endfunction

endpackage

// File: rtl/prng6_step.sv
// 6-bit generator register: load has priority over stepping, zero seeds fall back to Seed.
module prng6_step
  import rand_pkg::*;
#(
  parameter logic [GenW-1:0] Seed = SeedDefault
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [GenW-1:0] load_val,
  input  logic            en,
  output logic [GenW-1:0] state_o
);

  logic [GenW-1:0] state_d, state_q;

  // Next generator value: seed load, step, or hold.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_val == '0) ? Seed : load_val;
    end else if (en) begin
      state_d = prng_step(state_q);
    end
  end

  // Generator state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/rand_server.sv
// Round-robin server handing out one generator value per grant, then stepping
// the generator ADV_STEPS times in total before the next grant.
module rand_server
  import rand_pkg::*;
#(
  parameter int unsigned     N_REQ     = 4,
  parameter int unsigned     ADV_STEPS = 1,
  parameter logic [GenW-1:0] SEED      = SeedDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [GenW-1:0]  rnd_data,
  output logic             rnd_valid,
  input  logic             seed_load,
  input  logic [GenW-1:0]  seed,
  output logic             busy
);

  localparam int unsigned      PtrW    = $clog2(N_REQ);
  localparam logic [PtrW-1:0]  PtrLast = PtrW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] GntOne  = N_REQ'(1);
  // ADVANCE lasts ADV_STEPS-1 cycles; counter runs 0..AdvLast.
  localparam logic [5:0]       AdvLast = (ADV_STEPS > 1) ? 6'(ADV_STEPS - 2) : 6'd0;

  state_e           state_d, state_q;
  logic [PtrW-1:0]  ptr_d, ptr_q;
  logic [5:0]       cnt_d, cnt_q;
  logic [N_REQ-1:0] gnt_d, gnt_q;
  logic [GenW-1:0]  rnd_data_d, rnd_data_q;
  logic             rnd_valid_d, rnd_valid_q;
  logic             busy_d, busy_q;

  logic [GenW-1:0]  gen_state;
  logic             gen_en;
  logic [PtrW-1:0]  win;
  logic [PtrW-1:0]  cand;
  logic             found;

  prng6_step #(
    .Seed (SEED)
  ) u_prng (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_load),
    .load_val (seed),
    .en       (gen_en),
    .state_o  (gen_state)
  );

  // Round-robin search starting at the pointer; first requester found wins.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = PtrW'((32'(ptr_q) + i) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // FSM next state, generator control and registered output values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rnd_valid_d = 1'b0;
    rnd_data_d  = rnd_data_q;
    gen_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A seed load in IDLE takes precedence; the request stays pending.
        if (!seed_load && found) begin
          state_d     = StGrant;
          gnt_d       = GntOne << win;
          rnd_data_d  = gen_state;
          rnd_valid_d = 1'b1;
          gen_en      = 1'b1;
          ptr_d       = (win == PtrLast) ? '0 : win + PtrW'(1);
        end
      end
      StGrant: begin
        if (seed_load) begin
          state_d = StIdle;
        end else if (ADV_STEPS > 1) begin
          state_d = StAdvance;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StAdvance: begin
        if (seed_load) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          gen_en = 1'b1;
          if (cnt_q == AdvLast) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rnd_data_q  <= '0;
      rnd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rnd_data_q  <= rnd_data_d;
      rnd_valid_q <= rnd_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_data  = rnd_data_q;
  assign rnd_valid = rnd_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rand_server.sv
// Directed bench for rand_server: one instance with ADV_STEPS=1, one with ADV_STEPS=2.
module tb_rand_server;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic [3:0] req_a, gnt_a;
  logic [5:0] data_a, seed_a;
  logic       valid_a, seed_load_a, busy_a;

  logic [3:0] req_b, gnt_b;
  logic [5:0] data_b, seed_b;
  logic       valid_b, seed_load_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rand_server #(
    .N_REQ     (4),
    .ADV_STEPS (1),
    .SEED      (6'h09)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_a),
    .gnt       (gnt_a),
    .rnd_data  (data_a),
    .rnd_valid (valid_a),
    .seed_load (seed_load_a),
    .seed      (seed_a),
    .busy      (busy_a)
  );

  rand_server #(
    .N_REQ     (4),
    .ADV_STEPS (2),
    .SEED      (6'h09)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_b),
    .gnt       (gnt_b),
    .rnd_data  (data_b),
    .rnd_valid (valid_b),
    .seed_load (seed_load_b),
    .seed      (seed_b),
    .busy      (busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_a = '0; seed_load_a = 1'b0; seed_a = '0;
    req_b = '0; seed_load_b = 1'b0; seed_b = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_gnt_a(input int max_cyc, output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < max_cyc) begin
      tick();
      cyc++;
      if (gnt_a != '0) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    req_a = '0; seed_load_a = 1'b0; seed_a = '0;
    req_b = '0; seed_load_b = 1'b0; seed_b = '0;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt_a !== 4'b0000) begin
      n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt_a);
    end
    n_checks++;
    if (data_a !== 6'h00) begin
      n_fail++; $display("FAIL reset_data: got %h want 00", data_a);
    end
    n_checks++;
    if (valid_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", valid_a);
    end
    n_checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b want 0/0", busy_a, busy_b);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [5:0] exp_v [4];
    int cyc;
    bit got;
    exp_v[0] = 6'h09; exp_v[1] = 6'h12; exp_v[2] = 6'h3E; exp_v[3] = 6'h0A;
    for (int i = 0; i < 4; i++) begin
      req_a = 4'b0001;
      wait_gnt_a(10, cyc, got);
      n_checks++;
      if (!got) begin
        n_fail++; $display("FAIL single_timeout[%0d]: no grant within %0d cycles", i, cyc);
      end
      n_checks++;
      if (gnt_a !== 4'b0001) begin
        n_fail++; $display("FAIL single_gnt[%0d]: got %b want 0001", i, gnt_a);
      end
      n_checks++;
      if (data_a !== exp_v[i]) begin
        n_fail++; $display("FAIL single_data[%0d]: got %h want %h", i, data_a, exp_v[i]);
      end
      n_checks++;
      if (valid_a !== 1'b1 || busy_a !== 1'b1) begin
        n_fail++; $display("FAIL single_valid[%0d]: valid %b busy %b want 1 1", i, valid_a, busy_a);
      end
      req_a = 4'b0000;
      tick();
      n_checks++;
      if (valid_a !== 1'b0 || gnt_a !== 4'b0000) begin
        n_fail++; $display("FAIL single_pulse[%0d]: valid %b gnt %b want 0 0000", i, valid_a, gnt_a);
      end
    end
  endtask

  task automatic test_adv2();
    int cyc;
    bit got;
    req_b = 4'b0001;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 10) begin
      tick(); cyc++;
      if (gnt_b != '0) got = 1'b1;
    end
    n_checks++;
    if (!got || gnt_b !== 4'b0001 || data_b !== 6'h09) begin
      n_fail++; $display("FAIL adv2_first: gnt %b data %h want 0001 09", gnt_b, data_b);
    end
    req_b = 4'b0000;
    tick();
    n_checks++;
    if (busy_b !== 1'b1 || gnt_b !== 4'b0000) begin
      n_fail++; $display("FAIL adv2_advance: busy %b gnt %b want 1 0000", busy_b, gnt_b);
    end
    req_b = 4'b0001;
    cyc = 1; got = 1'b0;
    while (!got && cyc < 10) begin
      tick(); cyc++;
      if (gnt_b != '0) got = 1'b1;
    end
    n_checks++;
    if (!got || cyc != 3) begin
      n_fail++; $display("FAIL adv2_interval: got %0d cycles want 3", cyc);
    end
    n_checks++;
    if (data_b !== 6'h3E || valid_b !== 1'b1) begin
      n_fail++; $display("FAIL adv2_second: data %h valid %b want 3e 1", data_b, valid_b);
    end
    req_b = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_rotate();
    int cyc;
    bit got;
    int idx;
    logic [3:0] exp_g;
    do_reset();
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      idx = k % 4;
      exp_g = 4'b0001 << idx;
      cyc = 0; got = 1'b0;
      while (!got && cyc < 10) begin
        tick(); cyc++;
        n_checks++;
        if ($countones(gnt_a) > 1) begin
          n_fail++; $display("FAIL rotate_onehot[%0d]: gnt %b", k, gnt_a);
        end
        if (gnt_a != '0) got = 1'b1;
      end
      n_checks++;
      if (gnt_a !== exp_g) begin
        n_fail++; $display("FAIL rotate_order[%0d]: got %b want %b", k, gnt_a, exp_g);
      end
      req_a[idx] = 1'b0;
      tick();
      n_checks++;
      if ($countones(gnt_a) > 1) begin
        n_fail++; $display("FAIL rotate_onehot_post[%0d]: gnt %b", k, gnt_a);
      end
      req_a[idx] = 1'b1;
    end
    req_a = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_zero_seed();
    int cyc;
    bit got;
    seed_a = 6'h00;
    seed_load_a = 1'b1;
    tick();
    seed_load_a = 1'b0;
    n_checks++;
    if (gnt_a !== 4'b0000 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL zseed_idle: gnt %b busy %b want 0000 0", gnt_a, busy_a);
    end
    req_a = 4'b0001;
    wait_gnt_a(10, cyc, got);
    n_checks++;
    if (!got || data_a !== 6'h09) begin
      n_fail++; $display("FAIL zseed_data: got %h want 09", data_a);
    end
    req_a = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_seed_with_req();
    int cyc;
    bit got;
    // One grant first so the generator holds 3E rather than 12.
    req_a = 4'b0001;
    wait_gnt_a(10, cyc, got);
    n_checks++;
    if (!got || data_a !== 6'h12) begin
      n_fail++; $display("FAIL sreq_pre: got %h want 12", data_a);
    end
    req_a = 4'b0000;
    tick();
    tick();
    req_a = 4'b0001;
    seed_a = 6'h12;
    seed_load_a = 1'b1;
    tick();
    seed_load_a = 1'b0;
    n_checks++;
    if (gnt_a !== 4'b0000 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL sreq_nogrant: gnt %b valid %b busy %b want 0000 0 0",
                         gnt_a, valid_a, busy_a);
    end
    tick();
    n_checks++;
    if (gnt_a !== 4'b0001 || data_a !== 6'h12) begin
      n_fail++; $display("FAIL sreq_grant: gnt %b data %h want 0001 12", gnt_a, data_a);
    end
    req_a = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    int cyc;
    bit got;
    req_a = 4'b0001;
    tick();
    n_checks++;
    if (gnt_a !== 4'b0001 || data_a !== 6'h3E) begin
      n_fail++; $display("FAIL rmid_pre: gnt %b data %h want 0001 3e", gnt_a, data_a);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt_a !== 4'b0000 || valid_a !== 1'b0 || data_a !== 6'h00 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL rmid_drop: gnt %b valid %b data %h busy %b want 0000 0 00 0",
                         gnt_a, valid_a, data_a, busy_a);
    end
    req_a = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    // Pointer was 1 before reset; after reset requester 0 must win over 3.
    req_a = 4'b1001;
    wait_gnt_a(10, cyc, got);
    n_checks++;
    if (!got || gnt_a !== 4'b0001 || data_a !== 6'h09) begin
      n_fail++; $display("FAIL rmid_after: gnt %b data %h want 0001 09", gnt_a, data_a);
    end
    req_a = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_adv2();
    test_rotate();
    test_zero_seed();
    test_seed_with_req();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rand_server.md
# rand_server

Shares one 6-bit pseudo-random generator among `N_REQ` requesters. Round-robin arbitration, one value per grant. After each grant the generator is stepped a fixed number of times before the next grant, so consecutive consumers do not see adjacent sequence values. The block also owns seeding of the generator. It sits between the generator and the consumer blocks that previously each clocked a private copy.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ADV_STEPS`, 1: generator steps per grant, 1..63.
- `SEED`, 6'h09: reset and fallback seed; must be nonzero.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in `N_REQ`: level request, one bit per requester.
- `gnt` out `N_REQ`: one-hot grant, high for exactly one cycle.
- `rnd_data` out 6: value delivered with the grant; holds until the next grant.
- `rnd_valid` out 1: high in the grant cycle only.
- `seed_load` in 1: single-cycle pulse; loads `seed`.
- `seed` in 6: new generator state.
- `busy` out 1: high when state is not IDLE.

## Operation
- Generator step, with state bits s[5:0]:
  - s0' = s0^s3^s2
  - s1' = s1^s0
  - s2' = s2^s1
  - s3' = s4
  - s4' = s4^s3
  - s5' = s5^s4
- All-zero is a fixed point. A `seed_load` with `seed`==0 loads `SEED` instead.
- The generator steps only on the IDLE->GRANT edge and in each ADVANCE cycle. It never steps while idle, so the sequence is deterministic per grant.
- FSM:
  - IDLE: if `seed_load`, load the generator and stay in IDLE. Otherwise, if `req`!=0, pick the winner and go to GRANT.
  - GRANT: go to ADVANCE if `ADV_STEPS`>1, else to IDLE.
  - ADVANCE: counts `ADV_STEPS`-1 cycles, then goes to IDLE.
- On the IDLE->GRANT edge, all registered:
  - `gnt` <= one-hot winner.
  - `rnd_data` <= current generator state.
  - `rnd_valid` <= 1.
  - generator <= step(state).
  - pointer <= winner+1, wrapping at `N_REQ`.
- Arbitration: round-robin starting at the pointer. The pointer resets to 0, so requester 0 has priority.
- `req` is not sampled in GRANT or ADVANCE.
- Requester rule: hold `req` until `gnt` is seen, and drop it on the edge where `gnt` is sampled high.
- `seed_load` in GRANT: the grant still completes (outputs already registered). The generator loads the seed instead of stepping, and the next state is IDLE.
- `seed_load` in ADVANCE: the remaining steps are aborted, the seed is loaded, and the next state is IDLE.
- `seed_load` together with a pending `req` in IDLE: seed wins. No grant that cycle; the request stays pending.
- Reset values: generator=`SEED`, state IDLE, `gnt`=0, `rnd_data`=0, `rnd_valid`=0, `busy`=0, pointer=0, step counter=0. Reset mid-grant drops the grant immediately.

## Timing
- Request-to-grant latency: 1 cycle from `req` sampled in IDLE.
- Grant-to-grant minimum interval: `ADV_STEPS`+1 cycles (GRANT, ADVANCE x(`ADV_STEPS`-1), IDLE).
- Steps per grant: exactly `ADV_STEPS`.
- `busy` is registered and mirrors the state: 1 in GRANT and ADVANCE.
- Seed load takes effect on the next edge. The first grant after a seed returns the loaded value.

## Structure
- Package `rand_pkg`:
  - state enum (IDLE, GRANT, ADVANCE);
  - `SEED` default;
  - generator width constant (6);
  - step function.
- Sub-module `prng6_step`: 6-bit generator register with `load`, `load_val`, `en`, async active-low reset to `SEED`, zero-seed substitution.
- Top level: FSM, round-robin pointer, step counter, output registers.

## Test plan
- Reset, `ADV_STEPS`=1, `req`=4'b0001 held, dropped after each `gnt` and reasserted. Grants return 6'h09, 6'h12, 6'h3E, 6'h0A, each with `rnd_valid` high for 1 cycle.
- `ADV_STEPS`=2, single requester. Grants return 6'h09 then 6'h3E, 3 cycles apart.
- `req`=4'b1111 held, with each granted bit dropped and reasserted. Grants rotate 0,1,2,3,0, and `gnt` is never multi-hot.
- `seed_load` with `seed`=6'h00 in IDLE, then a request. The grant returns 6'h09.
- `seed_load` (`seed`=6'h12) in the same cycle as `req`. No grant that cycle; the next cycle grants with value 6'h12.
- `rst_n` low during GRANT. `gnt`, `rnd_valid` and `rnd_data` are 0 immediately, and the next grant returns 6'h09 to requester 0.
